ped_emerg_scheduler: RTL

PED_EMERG_SCHEDULER -- requirements
Module: ped_emerg_scheduler

---
 rtl/traffic_pkg.sv | 25 ++
 rtl/rr_pick4.sv | 23 ++
 rtl/ped_emerg_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings and timing defaults for the pedestrian/emergency scheduler.
package traffic_pkg;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_WALK, S_EMERG} state_t;
  typedef enum logic [1:0] {T_NONE, T_WALK, T_EMERG} target_t;

  localparam int WALK_T_DEF    = 10;
  localparam int CLEAR_T_DEF   = 3;
  localparam int EMERG_MAX_DEF = 40;
  localparam int CNT_W         = 6;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] lowest_bit(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin pick of one request out of four, searching upward from ptr.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] onehot,
  output logic       valid
);

  logic [1:0] idx;

  // Scan from farthest to nearest so the bit closest to ptr is written last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) onehot = 4'b0001 << idx;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/ped_emerg_scheduler.sv
// Pedestrian walk / emergency pre-emption scheduler with all-red clearance.
// state | meaning: IDLE no hold | CLEAR all-red countdown | WALK one walk lit | EMERG one emergency green
module ped_emerg_scheduler
  import traffic_pkg::*;
#(
  parameter int WALK_T    = WALK_T_DEF,
  parameter int CLEAR_T   = CLEAR_T_DEF,
  parameter int EMERG_MAX = EMERG_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ped_req,
  input  logic [3:0] emerg_req,
  output logic       hold_traffic,
  output logic [3:0] walk,
  output logic [3:0] emerg_grant,
  output logic [3:0] pending,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_T);
  localparam logic [CNT_W-1:0] WALK_LD  = CNT_W'(WALK_T);
  localparam logic [CNT_W-1:0] EMERG_LD = CNT_W'(EMERG_MAX);

  state_t           state, state_n;
  target_t          target, target_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       rr_ptr, rr_ptr_n;
  logic [3:0]       mask, mask_n;
  logic [3:0]       pending_n, walk_n, grant_n;
  logic [3:0]       emerg_live, pick_onehot;
  logic             pick_valid, last;

  rr_pick4 u_pick (
    .req    (pending),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .valid  (pick_valid)
  );

  assign emerg_live = emerg_req & ~mask;
  assign last       = (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      target       <= T_NONE;
      cnt          <= '0;
      rr_ptr       <= '0;
      mask         <= '0;
      pending      <= '0;
      walk         <= '0;
      emerg_grant  <= '0;
      hold_traffic <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      target       <= target_n;
      cnt          <= cnt_n;
      rr_ptr       <= rr_ptr_n;
      mask         <= mask_n;
      pending      <= pending_n;
      walk         <= walk_n;
      emerg_grant  <= grant_n;
      hold_traffic <= (state_n != S_IDLE);
      busy         <= (state_n != S_IDLE);
    end
  end

  always_comb begin
    state_n   = state;
    target_n  = target;
    cnt_n     = cnt;
    rr_ptr_n  = rr_ptr;
    mask_n    = mask & emerg_req;
    pending_n = pending | ped_req;
    walk_n    = walk;
    grant_n   = emerg_grant;
    case (state)
      S_IDLE: begin
        if (|emerg_live) begin
          state_n  = S_CLEAR;
          target_n = T_EMERG;
          cnt_n    = CLEAR_LD;
        end else if (|pending) begin
          state_n  = S_CLEAR;
          target_n = T_WALK;
          cnt_n    = CLEAR_LD;
        end
      end
      S_CLEAR: begin
        if (|emerg_live) target_n = T_EMERG;
        if (last) begin
          // A target whose requests vanished during clearance falls back to IDLE.
          if (target_n == T_EMERG && (|emerg_live)) begin
            state_n = S_EMERG;
            grant_n = lowest_bit(emerg_live);
            cnt_n   = EMERG_LD;
          end else if (target_n == T_WALK && pick_valid) begin
            state_n   = S_WALK;
            walk_n    = pick_onehot;
            cnt_n     = WALK_LD;
            rr_ptr_n  = onehot_to_idx(pick_onehot) + 2'd1;
            pending_n = pending_n & ~pick_onehot;
          end else begin
            state_n = S_IDLE;
          end
          if (state_n != S_CLEAR) target_n = T_NONE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_WALK: begin
        if ((|emerg_live) || last) begin
          state_n  = S_CLEAR;
          walk_n   = '0;
          cnt_n    = CLEAR_LD;
          if (|emerg_live)  target_n = T_EMERG;
          else if (|pending) target_n = T_WALK;
          else               target_n = T_NONE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_EMERG: begin
        if (!(|(emerg_req & emerg_grant)) || last) begin
          if (|(emerg_req & emerg_grant)) mask_n = mask_n | emerg_grant;
          state_n  = S_CLEAR;
          target_n = T_NONE;
          grant_n  = '0;
          cnt_n    = CLEAR_LD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n  = S_IDLE;
        target_n = T_NONE;
      end
    endcase
  end

endmodule
